pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register. It is the successor to the fixed-field ID/EXE latch. It carries a CTRL_W-bit control bundle and a DATA_W-bit data bundle between any two pipeline stages under a valid/ready handshake. It adds stall back-pressure, synchronous flush (bubble insertion) and a saturating stall-cycle counter. Instances sit between the IF/ID, ID/EXE, EXE/MEM and MEM/WB boundaries of the MIPS pipeline.

## Interface
- CTRL_W, 16, control-bundle width (RegWrite, MemWrite, ALUop, ...); these bits are zeroed in bubbles
- DATA_W, 128, data-bundle width (PC+4, operands, immediate, register fields)
- CNT_W, 16, stall-counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous kill of all held beats
- in_valid  input  1  upstream beat present
- in_ready  output  1  stage accepts a beat this cycle
- in_ctrl  input  CTRL_W  upstream control bundle
- in_data  input  DATA_W  upstream data bundle
- out_valid  output  1  downstream beat present
- out_ready  input  1  downstream accepts
- out_ctrl  output  CTRL_W  registered control bundle; all zeros when out_valid=0
- out_data  output  DATA_W  registered data bundle; holds its last value when out_valid=0
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Storage: one main entry drives the outputs, plus one skid entry (with PIPE_SKID_EN).
- State (skid build):
  - EMPTY: main entry invalid.
  - ONE: main entry valid, skid entry empty.
  - TWO: both entries valid.
- Transitions:
  - EMPTY + input transfer -> ONE; main loads the input.
  - ONE + input + output transfer -> ONE; main is replaced by the input.
  - ONE + input transfer only -> TWO; skid loads the input.
  - ONE + output transfer only -> EMPTY.
  - TWO + out_ready -> ONE; main loads from skid.
  - in_ready is 0 in TWO, so no input is accepted there.
- flush=1: next state is EMPTY and both valids clear.
  - out_ctrl reads zero on the next cycle.
  - A beat presented in the same cycle is dropped, because flush wins over accept.
  - Data registers are not cleared.
- Beat ordering is strictly FIFO. No beat is duplicated or lost, except under flush.
- stall_cnt increments by 1 per stall cycle and saturates at 2^CNT_W-1.
  - Only rst_n clears it; flush does not.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0.
  - State EMPTY.
  - in_ready=1 (skid build); in_ready=1 via its combinational equation otherwise.
- Reset asserts asynchronously. A reset mid-transfer discards all held beats.
- Latency: an input accepted in cycle N appears on the outputs in cycle N+1 when the stage is EMPTY or ONE with out_ready=1.
- Throughput: one beat per cycle while out_ready=1.
- Skid build:
  - in_ready is a register output, 1 exactly when the next state is not TWO.
  - No combinational path from out_ready to in_ready.
- Flush takes effect at the clock edge: out_valid=0 in cycle N+1 for flush in cycle N.
- Stall counter: the count is visible one cycle after the stall cycle it records.

## Configuration
- PIPE_SKID_EN defined:
  - Two-entry skid buffer as above.
  - Registered in_ready, for full throughput without a ready combinational chain.
- PIPE_SKID_EN undefined:
  - Single entry; states EMPTY/ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - Same latency and flush semantics. TWO is unreachable.

## Structure
- Package pipe_pkg holds:
  - the state enum typedef (EMPTY, ONE, TWO);
  - default-width constants (CTRL_W, DATA_W, CNT_W defaults);
  - the CTRL bit-index constants shared by the stages.
- One sub-module, pipe_stall_counter: a CNT_W-bit saturating counter with an enable, reset on rst_n.

## Test plan
- Reset and single beat:
  - Stimulus: release rst_n, then present in_valid=1, ctrl=16'h00A5, data=128'h1234 for one cycle with out_ready=1.
  - Required: out_valid=1 with 00A5/1234 on the next cycle, out_valid=0 the cycle after; stall_cnt=0.
- Back-pressure:
  - Stimulus: out_ready=0 while beats A, B, C are offered.
  - Required: A and B are accepted. In the skid build in_ready=0 from the cycle after B and C waits. The outputs hold A. stall_cnt counts each held cycle.
  - Release: raise out_ready; A, B, C emerge in order, each exactly once.
- Flush with simultaneous accept:
  - Stimulus: stage in TWO; assert flush with in_valid=1 and beat D.
  - Required: next cycle out_valid=0, out_ctrl=0, and D is never output.
- Streaming:
  - Stimulus: 100 back-to-back beats with an incrementing data value, out_ready=1.
  - Required: 100 outputs, in order, one per cycle, with a 1-cycle lag.
- Saturation:
  - Stimulus: CNT_W=4, hold a stall for 20 cycles.
  - Required: stall_cnt stops at 15; flush leaves it at 15; rst_n clears it to 0.
- Async reset mid-stall:
  - Stimulus: drop rst_n between clock edges while in TWO.
  - Required: out_valid falls immediately and stall_cnt=0. After release the stage is EMPTY and in_ready=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stage registers.
// Holds the occupancy state enum, default bundle widths and control-bundle bit indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

    localparam int unsigned CtrlWDefault = 16;
    localparam int unsigned DataWDefault = 128;
    localparam int unsigned CntWDefault  = 16;

    // Bit positions inside the control bundle, common to every stage boundary.
    localparam int unsigned CtrlRegWrite = 0;
    localparam int unsigned CtrlMemWrite = 1;
    localparam int unsigned CtrlMemRead  = 2;
    localparam int unsigned CtrlMemToReg = 3;
    localparam int unsigned CtrlBranch   = 4;
    localparam int unsigned CtrlAluSrc   = 5;
    localparam int unsigned CtrlRegDst   = 6;
    localparam int unsigned CtrlAluOpLsb = 7;
    localparam int unsigned CtrlAluOpMsb = 10;
    localparam int unsigned CtrlJump     = 11;

    function automatic logic holds_beat(pipe_state_e st);
        return st != StEmpty;
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating up-counter with enable; counts back-pressure cycles of a pipeline stage.
// Cleared only by the asynchronous reset.
module pipe_stall_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with synchronous flush and a stall counter.
// Define PIPE_SKID_EN for the two-entry skid build with a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CtrlWDefault,
    parameter int unsigned DATA_W = DataWDefault,
    parameter int unsigned CNT_W  = CntWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              in_xfer;
    logic              out_xfer;
    logic              stall_en;

    assign out_valid = holds_beat(state_q);
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign out_xfer  = out_valid & out_ready;
    // Flush wins over accept: a beat offered alongside flush is dropped.
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign stall_en  = out_valid & ~out_ready;

`ifdef PIPE_SKID_EN
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (in_xfer) begin
                    state_d     = StTwo;
                    skid_ctrl_d = in_ctrl;
                    skid_data_d = in_data;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_ready) begin
                    state_d     = StOne;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (flush) begin
            state_d = StEmpty;
        end
        // Bubbles carry no control, so a stale bundle can never fire a write.
        if (state_d == StEmpty) begin
            main_ctrl_d = '0;
        end
        in_ready_d = (state_d != StTwo);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;

        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d     = StOne;
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end
            end
            StOne: begin
                // Accepting here implies out_ready, so the held beat leaves as the new one lands.
                if (in_xfer) begin
                    main_ctrl_d = in_ctrl;
                    main_data_d = in_data;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (flush) begin
            state_d = StEmpty;
        end
        if (state_d == StEmpty) begin
            main_ctrl_d = '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_en),
        .cnt   (stall_cnt)
    );

endmodule
